// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32IC fetch constants, FSM encoding and reset PC default.
package rv_pkg;
  localparam int ILEN = 32;
  localparam int HWORD = 16;
  localparam logic [1:0] C_OPCODE_FULL = 2'b11;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, BUSY, DROP} fa_state_e;
  function automatic logic is_compressed(input logic [HWORD-1:0] h);
    return h[1:0] != C_OPCODE_FULL;
  endfunction
endpackage

// File: rtl/halfword_queue.sv
// halfword_queue: 3-slot halfword shift buffer; pop 0-2 from the head, then append 0-2 behind the survivors.
module halfword_queue
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       pop_n,
  input  logic [1:0]       push_n,
  input  logic [HWORD-1:0] push_a,
  input  logic [HWORD-1:0] push_b,
  output logic [HWORD-1:0] hw0,
  output logic [HWORD-1:0] hw1,
  output logic [1:0]       cnt
);
  logic [HWORD-1:0] r_hw [3];
  logic [HWORD-1:0] w_sh [3];
  logic [HWORD-1:0] w_nxt [3];
  logic [1:0]       r_cnt;
  logic [1:0]       w_rem;
  always_comb begin
    w_rem = r_cnt - pop_n;
    w_sh[0] = pop_n == 2'd0 ? r_hw[0] : pop_n == 2'd1 ? r_hw[1] : r_hw[2];
    w_sh[1] = pop_n == 2'd0 ? r_hw[1] : pop_n == 2'd1 ? r_hw[2] : '0;
    w_sh[2] = pop_n == 2'd0 ? r_hw[2] : '0;
    for (int i = 0; i < 3; i++)
      w_nxt[i] = (push_n != 2'd0 && w_rem == 2'(i)) ? push_a :
                 (push_n == 2'd2 && w_rem + 2'd1 == 2'(i)) ? push_b : w_sh[i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hw <= '{default: '0};
    end else if (clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_rem + push_n;
      r_hw <= w_nxt;
    end
  end
  assign hw0 = r_hw[0];
  assign hw1 = r_hw[1];
  assign cnt = r_cnt;
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: fetches 32-bit words and presents one aligned RV32IC instruction per handshake.
module fetch_aligner
  import rv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ILEN-1:0]   inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_is_c
);
  fa_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_fetch_addr;
  logic              r_skip_lo;
  logic [HWORD-1:0]  w_hw0, w_hw1;
  logic [1:0]        w_cnt, w_pop_n, w_push_n;
  logic              w_c, w_pop, w_push, w_unused;
  halfword_queue u_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect),
    .pop_n (w_pop_n),
    .push_n(w_push_n),
    .push_a(r_skip_lo ? mem_rdata[31:16] : mem_rdata[15:0]),
    .push_b(mem_rdata[31:16]),
    .hw0   (w_hw0),
    .hw1   (w_hw1),
    .cnt   (w_cnt)
  );
  assign w_unused = redirect_pc[0];
  assign w_c = is_compressed(w_hw0);
  assign inst_valid = !redirect && (w_cnt >= 2'd2 || (w_cnt == 2'd1 && w_c));
  assign inst = w_c ? {{(ILEN-HWORD){1'b0}}, w_hw0} : {w_hw1, w_hw0};
  assign inst_is_c = w_cnt != 2'd0 && w_c;
  assign inst_pc = r_pc;
  assign mem_addr = r_fetch_addr;
  assign w_pop = inst_valid && inst_ready;
  // A response landing in the redirect cycle belongs to the old stream and is dropped.
  assign w_push = r_state == BUSY && mem_rvalid && !redirect;
  assign w_pop_n = !w_pop ? 2'd0 : w_c ? 2'd1 : 2'd2;
  assign w_push_n = !w_push ? 2'd0 : r_skip_lo ? 2'd1 : 2'd2;
  always_comb begin
    mem_req = rst_n && !redirect && r_state == IDLE && w_cnt <= 2'd1;
    w_state_nxt = r_state == IDLE ? (mem_req ? BUSY : IDLE) :
                  r_state == BUSY ? (mem_rvalid ? IDLE : redirect ? DROP : BUSY) :
                  (mem_rvalid ? IDLE : DROP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_fetch_addr <= {RESET_PC[ADDR_W-1:2], 2'b00};
      r_skip_lo <= RESET_PC[1];
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
        r_fetch_addr <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_skip_lo <= redirect_pc[1];
      end else begin
        if (w_pop) r_pc <= r_pc + ADDR_W'({w_pop_n, 1'b0});
        if (w_push) begin
          r_fetch_addr <= r_fetch_addr + ADDR_W'(4);
          r_skip_lo <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: scoreboard bench; expected instruction stream derived from memory contents and a start PC.
module tb_fetch_aligner;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic        clk = 0, rst_n = 0, redirect = 0, mem_rvalid = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, mem_rdata = 0;
  logic        mem_req, inst_valid, inst_is_c;
  logic [31:0] mem_addr, inst, inst_pc;
  fetch_aligner #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_is_c(inst_is_c)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic c;} exp_t;
  exp_t        q[$];
  logic [31:0] mem [256];
  int          total = 0, bad = 0, popped = 0, all_pops = 0, lat_fix = 0, cd = 0;
  logic        pend = 0, req_seen = 0;
  logic [31:0] paddr = 0, req_addr = 0;
  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction
  // Walk the halfword stream from start; low bits 11 mean a 32-bit instruction.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] p;
    logic [15:0] h;
    p = {start[31:1], 1'b0};
    q.delete();
    for (int i = 0; i < 512; i++) begin
      h = hw(p);
      if (h[1:0] != 2'b11) begin
        q.push_back(exp_t'{{16'h0, h}, p, 1'b1});
        p = p + 2;
      end else begin
        q.push_back(exp_t'{{hw(p + 2), h}, p, 1'b0});
        p = p + 4;
      end
    end
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    req_seen = rst_n && mem_req;
    req_addr = mem_addr;
    if (rst_n && mem_req) begin
      chk("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      chk("req_while_pending", {31'h0, pend}, 32'h0);
    end
    if (rst_n && redirect) chk("req_on_redirect", {31'h0, mem_req}, 32'h0);
    if (rst_n && inst_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL q_empty act=%h exp=none", inst);
      end else begin
        chk("inst", inst, q[0].inst);
        chk("inst_pc", inst_pc, q[0].pc);
        chk("is_c", {31'h0, inst_is_c}, {31'h0, q[0].c});
        if (inst_ready) begin
          void'(q.pop_front());
          popped++;
          all_pops++;
        end
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    mem_rvalid = 0;
    mem_rdata = $urandom;
    if (pend) begin
      if (cd == 0) begin
        mem_rvalid = 1;
        mem_rdata = mem[paddr[9:2]];
        pend = 0;
      end else cd--;
    end
    if (req_seen) begin
      pend = 1;
      paddr = req_addr;
      cd = lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 3));
    end
  end
  task automatic do_reset();
    rst_n = 0;
    redirect = 0;
    q.delete();
    repeat (6) step();
    @(negedge clk);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, RPC);
    chk("rst_is_c", {31'h0, inst_is_c}, 32'h0);
    step();
    load_stream(RPC);
    popped = 0;
    rst_n = 1;
  endtask
  task automatic do_redirect(input logic [31:0] a);
    redirect = 1;
    redirect_pc = a;
    load_stream(a);
    step();
    redirect = 0;
    popped = 0;
  endtask
  task automatic wait_pops(input int n, input string nm);
    int t = 0;
    while (popped < n && t < 400) begin
      step();
      t++;
    end
    chk(nm, popped >= n ? 32'd1 : 32'd0, 32'd1);
  endtask
  // Returns at the negedge where mem_req is high; caller resyncs to posedge.
  task automatic wait_req(input string nm);
    int t = 0;
    @(negedge clk);
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(nm, {31'h0, mem_req}, 32'h1);
  endtask
  initial begin
    logic [31:0] w, a;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    lat_fix = 0;
    inst_ready = 1;
    do_reset();
    wait_pops(2, "two_full_insts");
    mem[0] = 32'h0093_4505;
    mem[1] = 32'h4501_0050;
    do_reset();
    wait_pops(3, "straddle");
    inst_ready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 7) chk("stall_no_req", {31'h0, mem_req}, 32'h0);
      step();
    end
    do_redirect(32'h0000_0102);
    @(negedge clk);
    chk("redir_req", {31'h0, mem_req}, 32'h1);
    chk("redir_addr", mem_addr, 32'h0000_0100);
    step();
    inst_ready = 1;
    wait_pops(3, "redir_stream");
    lat_fix = 3;
    wait_req("drop_req");
    step();
    do_redirect(32'h0000_0200);
    @(negedge clk);
    chk("drop_no_req", {31'h0, mem_req}, 32'h0);
    wait_req("after_drop_req");
    chk("after_drop_addr", mem_addr, 32'h0000_0200);
    step();
    wait_pops(3, "after_drop_stream");
    wait_req("rst_busy_req");
    step();
    do_reset();
    lat_fix = -1;
    wait_pops(3, "after_reset_stream");
    for (int i = 0; i < 3000; i++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 39) == 0 || i % 250 == 249) begin
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
        do_redirect(a);
      end else step();
    end
    chk("progress", all_pops > 500 ? 32'd1 : 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
